// File: rtl/fp_multiplier_pipelined_vedic_pkg.sv
// Shared definitions for the pipelined FP multiplier: operand classes and
// width/bias helpers used by the interface and the datapath.
package fp_multiplier_pipelined_vedic_pkg;

    // Operand class; denormals are folded into ZERO at unpack time.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_multiplier_pipelined_vedic_if.sv
// Operand/result bus of the FP multiplier with valid/ready on both sides.
interface fp_multiplier_pipelined_vedic_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    import fp_multiplier_pipelined_vedic_pkg::*;

    localparam int FP_W = fp_width(EXP_W, MAN_W);

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] mul_out;
    logic            flag_ovf;
    logic            flag_unf;
    logic            flag_inv;
    logic            flag_inx;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, mul_out, flag_ovf, flag_unf, flag_inv, flag_inx
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, mul_out, flag_ovf, flag_unf, flag_inv, flag_inx
    );

endinterface

// File: rtl/fp_multiplier_pipelined_vedic_vedic.sv
// Combinational NxN unsigned Vedic (Urdhva-Tiryakbhyam) multiplier.
// Even widths split into four half-width vertical/crosswise products;
// odd widths peel off the top bit so the remainder is even again.
module vedic_multiplier_nxn #(
    parameter int N = 24
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    if (N == 1) begin : g_n1
        assign p_o = {1'b0, a_i[0] & b_i[0]};
    end else if (N == 2) begin : g_n2
        // 2x2 base cell: vertical, crosswise, vertical
        logic c1;
        assign c1     = a_i[1] & b_i[0] & a_i[0] & b_i[1];
        assign p_o[0] = a_i[0] & b_i[0];
        assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
        assign p_o[2] = (a_i[1] & b_i[1]) ^ c1;
        assign p_o[3] = (a_i[1] & b_i[1]) & c1;
    end else if (N % 2 == 1) begin : g_odd
        localparam int M1 = N - 1;
        logic [2*M1-1:0] pl;
        logic [M1-1:0]   xa;
        logic [M1-1:0]   xb;
        vedic_multiplier_nxn #(.N(M1)) u_lo (
            .a_i(a_i[M1-1:0]), .b_i(b_i[M1-1:0]), .p_o(pl)
        );
        // 1-bit top rows: crosswise terms are just gated copies of the low half
        assign xa  = b_i[N-1] ? a_i[M1-1:0] : '0;
        assign xb  = a_i[N-1] ? b_i[M1-1:0] : '0;
        assign p_o = {2'b00, pl}
                   + {2'b00, xa, {M1{1'b0}}}
                   + {2'b00, xb, {M1{1'b0}}}
                   + {1'b0, a_i[N-1] & b_i[N-1], {(2*M1){1'b0}}};
    end else begin : g_even
        localparam int H = N / 2;
        logic [N-1:0] ll, lh, hl, hh;
        vedic_multiplier_nxn #(.N(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
        vedic_multiplier_nxn #(.N(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(lh));
        vedic_multiplier_nxn #(.N(H)) u_hl (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
        vedic_multiplier_nxn #(.N(H)) u_hh (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(hh));
        assign p_o = {hh, ll}
                   + {{H{1'b0}}, lh, {H{1'b0}}}
                   + {{H{1'b0}}, hl, {H{1'b0}}};
    end

endmodule

// File: rtl/fp_multiplier_pipelined_vedic.sv
// 3-stage FP multiplier: S1 unpack/classify, S2 Vedic significand product,
// S3 normalise, round-to-nearest-even, specials and pack. All stages move
// together on adv and freeze while the output is stalled.
module fp_multiplier_pipelined_vedic
    import fp_multiplier_pipelined_vedic_pkg::*;
#(
    parameter int EXP_W = SP_EXP_W,
    parameter int MAN_W = SP_MAN_W
) (
    input  logic clk_i,
    input  logic rst_i,
    fp_multiplier_pipelined_vedic_if.slave bus
);

    localparam int FP_W   = fp_width(EXP_W, MAN_W);
    localparam int M      = MAN_W + 1;
    localparam int PW     = 2 * M;
    localparam int EW2    = EXP_W + 2;
    localparam int STAGES = 3;

    localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXP_W));
    localparam logic signed [EW2-1:0] EMAX_S = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] ZERO_S = '0;
    localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [FP_W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef struct packed {
        logic                  sign;
        fp_cls_e               cls_a;
        fp_cls_e               cls_b;
        logic signed [EW2-1:0] esum;
        logic [M-1:0]          ma;
        logic [M-1:0]          mb;
    } s1_t;

    typedef struct packed {
        logic                  sign;
        fp_cls_e               cls_a;
        fp_cls_e               cls_b;
        logic signed [EW2-1:0] esum;
        logic [PW-1:0]         prod;
    } s2_t;

    typedef struct packed {
        logic [FP_W-1:0] res;
        logic            ovf;
        logic            unf;
        logic            inv;
        logic            inx;
    } out_t;

    function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (&e)      return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    logic [STAGES:1] vld_pipe_q;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    out_t            s3_d, out_q;
    logic [PW-1:0]   prod;
    logic            adv;

    assign adv           = !vld_pipe_q[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.mul_out   = out_q.res;
    assign bus.flag_ovf  = out_q.ovf;
    assign bus.flag_unf  = out_q.unf;
    assign bus.flag_inv  = out_q.inv;
    assign bus.flag_inx  = out_q.inx;

    // S1: sign, class, biased exponent sum and significands with hidden 1
    always_comb begin
        s1_d.sign  = bus.a[FP_W-1] ^ bus.b[FP_W-1];
        s1_d.cls_a = classify(bus.a[FP_W-2 -: EXP_W], bus.a[MAN_W-1:0]);
        s1_d.cls_b = classify(bus.b[FP_W-2 -: EXP_W], bus.b[MAN_W-1:0]);
        s1_d.esum  = $signed({2'b00, bus.a[FP_W-2 -: EXP_W]})
                   + $signed({2'b00, bus.b[FP_W-2 -: EXP_W]}) - BIAS_S;
        s1_d.ma    = {1'b1, bus.a[MAN_W-1:0]};
        s1_d.mb    = {1'b1, bus.b[MAN_W-1:0]};
    end

    vedic_multiplier_nxn #(.N(M)) u_vedic (
        .a_i(s1_q.ma),
        .b_i(s1_q.mb),
        .p_o(prod)
    );

    // S2: latch the product with class/exponent side-band
    always_comb begin
        s2_d.sign  = s1_q.sign;
        s2_d.cls_a = s1_q.cls_a;
        s2_d.cls_b = s1_q.cls_b;
        s2_d.esum  = s1_q.esum;
        s2_d.prod  = prod;
    end

    // S3: normalise to 1.f, RNE, exponent range checks, then specials on top
    logic                  hi, grd, stk, rnd, any_nan, any_inf, any_zero;
    logic [PW-2:0]         norm;
    logic [MAN_W:0]        frac_r;
    logic signed [EW2-1:0] exp_f;
    always_comb begin
        hi     = s2_q.prod[PW-1];
        norm   = hi ? s2_q.prod[PW-2:0] : {s2_q.prod[PW-3:0], 1'b0};
        grd    = norm[MAN_W];
        stk    = |norm[MAN_W-1:0];
        rnd    = grd & (stk | norm[MAN_W+1]);
        frac_r = {1'b0, norm[PW-2 -: MAN_W]} + (MAN_W+1)'(rnd);
        // carry-out leaves the fraction at zero, so only the exponent moves
        exp_f  = s2_q.esum + $signed(EW2'(hi)) + $signed(EW2'(frac_r[MAN_W]));

        any_nan  = (s2_q.cls_a == CLS_NAN) || (s2_q.cls_b == CLS_NAN);
        any_inf  = (s2_q.cls_a == CLS_INF) || (s2_q.cls_b == CLS_INF);
        any_zero = (s2_q.cls_a == CLS_ZERO) || (s2_q.cls_b == CLS_ZERO);

        s3_d     = '0;
        s3_d.res = {s2_q.sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
        s3_d.inx = grd | stk;
        if (exp_f >= EMAX_S) begin
            s3_d.res = {s2_q.sign, INF_MAG};
            s3_d.ovf = 1'b1;
            s3_d.inx = 1'b1;
        end else if (exp_f <= ZERO_S) begin
            s3_d.res = {s2_q.sign, {(FP_W-1){1'b0}}};
            s3_d.unf = 1'b1;
            s3_d.inx = 1'b1;
        end

        if (any_nan || (any_inf && any_zero)) begin
            s3_d     = '0;
            s3_d.res = QNAN;
            s3_d.inv = 1'b1;
        end else if (any_inf) begin
            s3_d     = '0;
            s3_d.res = {s2_q.sign, INF_MAG};
        end else if (any_zero) begin
            s3_d     = '0;
            s3_d.res = {s2_q.sign, {(FP_W-1){1'b0}}};
        end
    end

    // Stage registers and valid shift register; whole pipe moves on adv
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            out_q      <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            out_q      <= s3_d;
        end
    end

endmodule

// File: tb/tb_fp_multiplier_pipelined_vedic.sv
// Randomised + directed bench for the pipelined FP multiplier, checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_fp_multiplier_pipelined_vedic;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_multiplier_pipelined_vedic_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_multiplier_pipelined_vedic #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] expv;
    } op_t;

    typedef struct {
        logic [35:0] expv;
        int          t;
        bit          lat;
    } sb_t;

    op_t pend[$];
    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nres = 0;
    bit  lat_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: exact integer product, round by comparing the remainder to half an ulp
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        logic s, an, bn, ai, bi, az, bz, inx;
        longint unsigned p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        if (an || bn || (ai && bz) || (bi && az)) return {32'h7FC00000, 4'b0010};
        if (ai || bi) return {s, 8'hFF, 23'h0, 4'b0000};
        if (az || bz) return {s, 31'h0, 4'b0000};
        p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 4'b1001};
        if (e <= 0)   return {s, 31'h0, 4'b0101};
        return {s, 8'(e), 23'(q), 3'b000, inx};
    endfunction

    function automatic logic [31:0] rnd_op();
        int          c;
        logic        s;
        logic [22:0] f;
        logic [7:0]  e;
        c = $urandom_range(0, 15);
        s = 1'($urandom);
        f = 23'($urandom);
        case (c)
            0:       begin e = 8'h00; f = '0; end
            1:       begin e = 8'h00; f = f | 23'h1; end
            2:       begin e = 8'hFF; f = '0; end
            3:       begin e = 8'hFF; f = f | 23'h1; end
            4, 5:    e = 8'($urandom_range(160, 254));
            6, 7:    e = 8'($urandom_range(1, 72));
            8:       begin e = 8'd127; f = 23'h7FFFFF ^ 23'($urandom_range(0, 7)); end
            default: e = 8'($urandom_range(64, 190));
        endcase
        return {s, e, f};
    endfunction

    task automatic issue_x(input logic [31:0] a, input logic [31:0] b, input logic [35:0] expv);
        op_t o;
        o.a = a;
        o.b = b;
        o.expv = expv;
        pend.push_back(o);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        issue_x(a, b, model(a, b));
    endtask

    function automatic logic [35:0] obs_out();
        return {bus.mul_out, bus.flag_ovf, bus.flag_unf, bus.flag_inv, bus.flag_inx};
    endfunction

    // One clock: present the head of pend, then observe both handshakes
    task automatic step(input bit ordy);
        sb_t e;
        @(negedge clk);
        cyc++;
        bus.out_ready = ordy;
        if (pend.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.a = pend[0].a;
            bus.b = pend[0].b;
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                nres++;
                chk("result", 64'(obs_out()), 64'(e.expv));
                if (e.lat) chk("latency", 64'(cyc - e.t), 64'd3);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e.expv = pend[0].expv;
            e.t    = cyc;
            e.lat  = lat_mode;
            sb.push_back(e);
            void'(pend.pop_front());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend.size() > 0 || sb.size() > 0) && n < 400) begin
            step(1'b1);
            n++;
        end
        chk("drain", 64'(pend.size() + sb.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bit          held_v, saw_ir_low;
        int          base;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mul_out", 64'(bus.mul_out), 64'd0);
        chk("rst_flags", 64'({bus.flag_ovf, bus.flag_unf, bus.flag_inv, bus.flag_inx}), 64'd0);

        // directed cases, back-to-back with full-throughput latency checks
        lat_mode = 1'b1;
        issue_x(32'hC1900000, 32'hC1180000, {32'h432B0000, 4'b0000});
        issue_x(32'hC1A00000, 32'h42200000, {32'hC4480000, 4'b0000});
        issue_x(32'h3F800001, 32'h3F800001, {32'h3F800002, 4'b0001});
        issue_x(32'h7F000000, 32'h40000000, {32'h7F800000, 4'b1001});
        issue_x(32'h7F800000, 32'h00000000, {32'h7FC00000, 4'b0010});
        issue_x(32'h00800000, 32'h00800000, {32'h00000000, 4'b0101});
        issue(32'h3FFFFFFF, 32'h3FFFFFFF);
        issue(32'h3FFFFFFF, 32'h3F800001);
        issue(32'h7F800000, 32'hC0400000);
        issue(32'h80000000, 32'h3F800000);
        issue(32'h7FC00001, 32'h3F800000);
        drain();

        // random, no back-pressure
        for (int i = 0; i < 200; i++) issue(rnd_op(), rnd_op());
        drain();

        // random, with back-pressure
        lat_mode = 1'b0;
        for (int i = 0; i < 300; i++) issue(rnd_op(), rnd_op());
        for (int i = 0; i < 600 && (pend.size() > 0 || sb.size() > 0); i++)
            step($urandom_range(0, 3) != 0);
        drain();

        // 4-op stream into a stalled output
        base = nres;
        held_v = 1'b0;
        saw_ir_low = 1'b0;
        for (int i = 0; i < 4; i++) issue(rnd_op(), 32'h3F800000 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (bus.out_valid) begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                if (held_v) chk("stall_hold", 64'(bus.mul_out), 64'(held));
                held   = bus.mul_out;
                held_v = 1'b1;
            end
            if (!bus.in_ready) saw_ir_low = 1'b1;
        end
        chk("stall_saw_in_ready_low", 64'(saw_ir_low), 64'd1);
        chk("stall_pending", 64'(pend.size()), 64'd1);
        drain();
        chk("stall_count", 64'(nres - base), 64'd4);

        // reset with 3 ops in flight discards them
        lat_mode = 1'b1;
        for (int i = 0; i < 3; i++) issue(rnd_op(), rnd_op());
        for (int i = 0; i < 3; i++) step(1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_mul_out", 64'(bus.mul_out), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            chk("midrst_quiet", 64'(bus.out_valid), 64'd0);
        end
        issue(32'h40400000, 32'h40000000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
